// File: rtl/spi_packet_master.sv
// SPI mode-0 initiator for fixed-width packets: shifts tx_packet out MSB-first on MOSI
// while capturing MISO, and groups packets into SSEL frames using tx_last.
module spi_packet_master #(
  parameter int PACKET_WIDTH = 40,
  parameter int CLK_DIV      = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] tx_packet,
  input  logic                    tx_last,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [PACKET_WIDTH-1:0] rx_packet,
  output logic                    rx_valid,
  output logic                    busy,
  output logic                    spi_SCLK,
  output logic                    spi_SSEL,
  output logic                    spi_MOSI,
  input  logic                    spi_MISO
);

  localparam int BW = $clog2(PACKET_WIDTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PACKET_WIDTH - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE, WAIT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [PACKET_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [PACKET_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [PACKET_WIDTH-1:0] rx_packet_q, rx_packet_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic                    last_q, last_d;
  logic                    sclk_q, sclk_d;
  logic                    ssel_q, ssel_d;
  logic                    mosi_q, mosi_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    busy_q, busy_d;
  logic                    accept;

  assign accept = tx_valid && tx_ready_q;

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_packet_d = rx_packet_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_d      = last_q;
    sclk_d      = sclk_q;
    ssel_d      = ssel_q;
    mosi_d      = mosi_q;
    tx_ready_d  = tx_ready_q;
    rx_valid_d  = 1'b0;

    case (state_q)
      // IDLE and WAIT differ only in SSEL, which an accept pulls (or keeps) low
      IDLE, WAIT: begin
        tx_ready_d = 1'b1;
        if (accept) begin
          tx_shift_d = tx_packet;
          last_d     = tx_last;
          mosi_d     = tx_packet[PACKET_WIDTH-1];
          ssel_d     = 1'b0;
          sclk_d     = 1'b0;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          tx_ready_d = 1'b0;
          state_d    = LEAD;
        end
      end
      LEAD, LOW: begin
        if (div_cnt_q == DIV_END) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          state_d   = HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_cnt_q == DIV_END) begin
          div_cnt_d  = '0;
          sclk_d     = 1'b0;
          rx_shift_d = {rx_shift_q[PACKET_WIDTH-2:0], spi_MISO};
          if (bit_cnt_q == LAST_BIT) begin
            // publish here so rx_valid occupies the DONE cycle, never alongside tx_ready
            rx_packet_d = {rx_shift_q[PACKET_WIDTH-2:0], spi_MISO};
            rx_valid_d  = 1'b1;
            state_d     = DONE;
          end else begin
            mosi_d     = tx_shift_q[PACKET_WIDTH-2];
            tx_shift_d = {tx_shift_q[PACKET_WIDTH-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            state_d    = LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (last_q) begin
          ssel_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          tx_ready_d = 1'b1;
          state_d    = WAIT;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_END) begin
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_packet_q <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ssel_q      <= 1'b1;
      mosi_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_packet_q <= rx_packet_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_q      <= last_d;
      sclk_q      <= sclk_d;
      ssel_q      <= ssel_d;
      mosi_q      <= mosi_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign rx_packet = rx_packet_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign spi_SCLK  = sclk_q;
  assign spi_SSEL  = ssel_q;
  assign spi_MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_packet_master.sv
// Bench for spi_packet_master: a driver queues expected replies, and a monitor
// checks rx packets, MOSI bits per SCLK rise, frame lengths and inter-frame gaps.
module tb_spi_packet_master;

  localparam int PW        = 40;
  localparam int CLK_DIV   = 4;
  localparam int GAP       = 8;
  localparam int FRAME_LOW = 2 * PW * CLK_DIV + 1;

  typedef struct packed {
    logic [PW-1:0] rx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW-1:0] tx_packet = '0;
  logic          tx_last = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [PW-1:0] rx_packet;
  logic          rx_valid;
  logic          busy;
  logic          spi_SCLK;
  logic          spi_SSEL;
  logic          spi_MOSI;
  logic          spi_MISO;

  bit            mode = 1'b0;
  bit            exact_gap = 1'b0;
  logic [PW-1:0] slave_word = '0;
  int            slave_idx = 0;
  logic          slave_prev = 1'b0;

  exp_t          rxq[$];
  logic [PW-1:0] txq[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  spi_packet_master #(
    .PACKET_WIDTH(PW),
    .CLK_DIV(CLK_DIV),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tx_packet(tx_packet),
    .tx_last(tx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_packet(rx_packet),
    .rx_valid(rx_valid),
    .busy(busy),
    .spi_SCLK(spi_SCLK),
    .spi_SSEL(spi_SSEL),
    .spi_MOSI(spi_MOSI),
    .spi_MISO(spi_MISO)
  );

  // Slave model presents the next bit of slave_word after each SCLK fall
  assign spi_MISO = mode ? slave_word[PW-1-slave_idx] : spi_MOSI;

  always @(negedge clk) begin
    if (spi_SSEL || !reset_n) slave_idx <= 0;
    else if (slave_prev && !spi_SCLK) slave_idx <= (slave_idx + 1) % PW;
    slave_prev <= spi_SCLK;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [PW-1:0] pkt, input logic last);
    int   n = 0;
    exp_t e;
    tx_packet = pkt;
    tx_last   = last;
    tx_valid  = 1'b1;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      checkOutput("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.rx   = mode ? slave_word : pkt;
    e.last = last;
    rxq.push_back(e);
    txq.push_back(pkt);
    @(negedge clk);
    #1;
  endtask

  task automatic dropValid();
    tx_valid = 1'b0;
  endtask

  task automatic waitRx();
    int n = 0;
    while (rxq.size() != 0 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rxq.size() != 0) checkOutput("rx_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(!busy && spi_SSEL && rxq.size() == 0) && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 5000) checkOutput("idle_timeout", 0, 1);
  endtask

  // Monitor: every check is against the queued expectations or protocol timing rules
  initial begin
    int   rises = 0, low_cnt = 0, high_cnt = 0, frame_pkts = 0, edge_in_pkt = 0;
    logic prev_sclk = 1'b0, prev_ssel = 1'b1;
    bit   had_frame = 1'b0, check_next = 1'b0, exp_ssel = 1'b0;
    exp_t item;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rxq.delete();
        txq.delete();
        rises = 0; low_cnt = 0; high_cnt = 0; frame_pkts = 0; edge_in_pkt = 0;
        prev_sclk = 1'b0; prev_ssel = 1'b1;
        had_frame = 1'b0; check_next = 1'b0;
      end else begin
        if (check_next) begin
          checkOutput("ssel_after_rx", spi_SSEL, exp_ssel);
          check_next = 1'b0;
        end
        if (!spi_SSEL && prev_ssel) begin
          if (had_frame) begin
            if (exact_gap) checkOutput("gap_len", high_cnt, GAP + 1);
            else checkOutput("gap_min", high_cnt >= GAP + 1, 1);
          end
          low_cnt = 0; rises = 0; frame_pkts = 0; edge_in_pkt = 0;
        end
        if (spi_SSEL && !prev_ssel) begin
          checkOutput("frame_edges", rises, PW * frame_pkts);
          checkOutput("frame_sclk_low", spi_SCLK, 0);
          if (frame_pkts == 1) checkOutput("frame_low_len", low_cnt, FRAME_LOW);
          had_frame = 1'b1;
          high_cnt = 0;
        end
        if (!spi_SSEL) low_cnt++;
        else high_cnt++;
        if (spi_SCLK && !prev_sclk) begin
          rises++;
          if (txq.size() == 0) begin
            checkOutput("mosi_unexpected_edge", 1, 0);
          end else begin
            checkOutput("mosi_bit", spi_MOSI, txq[0][PW-1-edge_in_pkt]);
            edge_in_pkt++;
            if (edge_in_pkt == PW) begin
              void'(txq.pop_front());
              edge_in_pkt = 0;
            end
          end
        end
        if (rx_valid) begin
          checkOutput("rx_tx_ready_overlap", tx_ready, 0);
          if (rxq.size() == 0) begin
            checkOutput("rx_unexpected", 1, 0);
          end else begin
            item = rxq.pop_front();
            checkOutput("rx_packet", rx_packet, item.rx);
            frame_pkts++;
            check_next = 1'b1;
            exp_ssel = item.last;
          end
        end
        prev_sclk = spi_SCLK;
        prev_ssel = spi_SSEL;
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] rnd;
    logic        p;
    int          r, n;

    repeat (3) @(negedge clk);
    checkOutput("reset_ssel", spi_SSEL, 1);
    checkOutput("reset_sclk", spi_SCLK, 0);
    checkOutput("reset_mosi", spi_MOSI, 0);
    checkOutput("reset_tx_ready", tx_ready, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_packet", rx_packet, 0);
    checkOutput("reset_busy", busy, 0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_tx_ready", tx_ready, 1);

    $display("[TB] loopback single packet");
    applyStimulus(40'hA5_0123_4567, 1'b1);
    dropValid();
    waitRx();
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_fall_delay", n, GAP + 1);
    waitIdle();

    $display("[TB] slave pattern on MISO");
    slave_word = 40'hFF00_FF00_FF;
    mode = 1'b1;
    applyStimulus(40'h0, 1'b1);
    dropValid();
    waitIdle();
    mode = 1'b0;

    $display("[TB] burst of three");
    applyStimulus(40'd1, 1'b0);
    applyStimulus(40'd2, 1'b0);
    applyStimulus(40'd3, 1'b1);
    dropValid();
    waitIdle();

    $display("[TB] burst stalled in WAIT");
    applyStimulus(40'h12_3456_789A, 1'b0);
    dropValid();
    waitRx();
    repeat (50) @(negedge clk);
    checkOutput("wait_ssel", spi_SSEL, 0);
    checkOutput("wait_sclk", spi_SCLK, 0);
    checkOutput("wait_tx_ready", tx_ready, 1);
    checkOutput("wait_busy", busy, 1);
    applyStimulus(40'hFE_DCBA_9876, 1'b1);
    dropValid();
    waitIdle();

    $display("[TB] back-to-back frames");
    applyStimulus(40'h11_1111_1111, 1'b1);
    exact_gap = 1'b1;
    applyStimulus(40'h22_2222_2222, 1'b1);
    applyStimulus(40'h33_3333_3333, 1'b1);
    dropValid();
    waitIdle();
    exact_gap = 1'b0;

    $display("[TB] random packets");
    for (int i = 0; i < 6; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus(rnd[PW-1:0], (i == 5) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    dropValid();
    waitIdle();

    $display("[TB] reset mid-frame");
    applyStimulus(40'h5A_5A5A_5A5A, 1'b1);
    dropValid();
    p = spi_SCLK;
    r = 0;
    n = 0;
    while (r < 17 && n < 3000) begin
      @(negedge clk);
      if (spi_SCLK && !p) r++;
      p = spi_SCLK;
      n++;
    end
    checkOutput("abort_edges_seen", r, 17);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_ssel", spi_SSEL, 1);
    checkOutput("abort_sclk", spi_SCLK, 0);
    checkOutput("abort_mosi", spi_MOSI, 0);
    checkOutput("abort_rx_valid", rx_valid, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #1;
    applyStimulus(40'hC3_C3C3_0F0F, 1'b1);
    dropValid();
    waitIdle();
    checkOutput("rx_outstanding", rxq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
